// File: rtl/fetch_seq_pkg.sv
// Fetch sequencer shared types: FSM state, redirect source, defaults.
// Imported by fetch_sequencer and fetch_wait_timer.
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_IMEM_WAIT = 2'd1,
    ST_MD_WAIT   = 2'd2,
    ST_EXC_FLUSH = 2'd3
  } fs_state_e;

  // Redirect source, encoded so a larger value wins.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_BR   = 2'd1,
    RD_ERET = 2'd2,
    RD_EXC  = 2'd3
  } redir_e;

  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h00004180;
  localparam int          IMEM_TIMEOUT_DEF = 16;

  function automatic redir_e redir_sel(
    input logic exc,
    input logic eret,
    input logic br
  );
    redir_e r;
    r = RD_NONE;
    if (exc)       r = RD_EXC;
    else if (eret) r = RD_ERET;
    else if (br)   r = RD_BR;
    return r;
  endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// IMEM wait counter: counts wait cycles, pulses fetch_err on timeout.
// Ports: clk, rst_n, clr (zero count), inc (count), fetch_err (pulse).
module fetch_wait_timer
  import fetch_seq_pkg::*;
#(
  parameter int TIMEOUT = IMEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic fetch_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;
  logic          hit;

  // The timeout cycle pulses and restarts the count.
  assign hit       = inc & ~clr & (cnt == LAST);
  assign fetch_err = hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr | hit) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-side PC / pipeline register sequencer for the 5-stage core.
// Ports: imem handshake, D/M redirect + hazard inputs, PC and stage controls.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int          IMEM_TIMEOUT = IMEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic        br_taken_d,
  input  logic [31:0] br_target_d,
  input  logic        lw_use_d,
  input  logic        md_use_d,
  input  logic        md_busy,
  input  logic        exc_req_m,
  input  logic        eret_m,
  input  logic [31:0] epc,
  output logic        pc_en,
  output logic        pc_redirect,
  output logic [31:0] npc,
  output logic        stall_fd,
  output logic        flush_fd,
  output logic        stall_de,
  output logic        flush_de,
  output logic        flush_em,
  output logic        fetch_err
);

  fs_state_e state, nxt;
  logic      drop, drop_d;
  logic      pend, pend_d;

  logic   exc;
  logic   md_st;
  logic   hold_d;
  logic   br_ok;
  logic   in_wait;
  logic   base_en;
  logic   bub_fd;
  logic   req;
  logic   stay;
  logic   t_err;
  redir_e redir;

  assign exc     = exc_req_m | eret_m;
  assign in_wait = (state == ST_IMEM_WAIT);

  // In MD_WAIT the stall tracks md_busy alone.
  assign md_st  = (state == ST_MD_WAIT) ? md_busy
                                        : (md_use_d & md_busy);
  assign hold_d = lw_use_d | md_st;
  assign br_ok  = br_taken_d & ~hold_d & ~exc;
  assign redir  = redir_sel(exc_req_m, eret_m, br_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      drop  <= 1'b0;
      pend  <= 1'b0;
    end else begin
      state <= nxt;
      drop  <= drop_d;
      pend  <= pend_d;
    end
  end

  // Per-state fetch behaviour.
  always_comb begin
    base_en = 1'b0;
    bub_fd  = 1'b0;
    req     = 1'b1;
    unique case (state)
      ST_RUN: begin
        base_en = imem_ready;
        bub_fd  = ~imem_ready;
      end
      ST_IMEM_WAIT: begin
        // A beat arriving while drop is set
        // belongs to the abandoned PC.
        base_en = imem_ready & ~drop;
        bub_fd  = ~(imem_ready & ~drop);
      end
      ST_MD_WAIT: begin
        if (md_busy) begin
          req = 1'b0;
        end else begin
          base_en = imem_ready;
          bub_fd  = ~imem_ready;
        end
      end
      ST_EXC_FLUSH: begin
        base_en = 1'b1;
        bub_fd  = 1'b1;
      end
      default: begin
        base_en = 1'b0;
      end
    endcase
  end

  // Next state in priority order.
  always_comb begin
    nxt    = state;
    drop_d = drop;
    pend_d = pend;
    if (exc) begin
      // While waiting, the outstanding fetch must
      // be drained before entering EXC_FLUSH.
      if (in_wait) begin
        drop_d = 1'b1;
        pend_d = 1'b1;
      end else begin
        nxt = ST_EXC_FLUSH;
      end
    end else if (br_ok) begin
      if (in_wait) drop_d = 1'b1;
      else         nxt    = ST_RUN;
    end else if (in_wait && drop) begin
      if (imem_ready) begin
        drop_d = 1'b0;
        pend_d = 1'b0;
        if (pend) nxt = ST_EXC_FLUSH;
      end
    end else if (md_st) begin
      nxt = ST_MD_WAIT;
    end else if (state == ST_EXC_FLUSH) begin
      nxt = ST_RUN;
    end else begin
      nxt = imem_ready ? ST_RUN : ST_IMEM_WAIT;
    end
  end

  assign stay = in_wait & (nxt == ST_IMEM_WAIT);

  fetch_wait_timer #(
    .TIMEOUT (IMEM_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (~stay),
    .inc       (stay),
    .fetch_err (t_err)
  );

  always_comb begin
    npc = '0;
    unique case (redir)
      RD_EXC:  npc = EXC_VECTOR;
      RD_ERET: npc = epc;
      RD_BR:   npc = br_target_d;
      default: npc = '0;
    endcase
  end

  // Flush beats stall on the same register.
  assign pc_en       = rst_n & base_en & ~hold_d;
  assign pc_redirect = rst_n & (redir != RD_NONE);
  assign imem_req    = rst_n & req;
  assign flush_fd    = ~rst_n | exc | br_ok | bub_fd;
  assign flush_de    = ~rst_n | exc | hold_d;
  assign flush_em    = ~rst_n | exc;
  assign stall_fd    = rst_n & hold_d & ~flush_fd;
  assign stall_de    = 1'b0;
  assign fetch_err   = rst_n & t_err;

endmodule
